// File: rtl/sdram_avalon_bridge_pkg.sv
// Shared types and constants for the core-side SDRAM request to Avalon-MM bridge.
// Latency and backpressure are defined by the bridge FSM; this file holds no logic.
package sdram_bridge_pkg;

  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_DATA_W = 32;

  localparam logic [3:0] BE_ALL_N  = 4'b0000;
  localparam logic [3:0] BE_NONE_N = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    WR_CMD,
    RD_CMD,
    RD_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/sdram_avalon_bridge_watchdog.sv
// Read watchdog: counts RD_WAIT cycles, tc asserts combinationally at RD_TIMEOUT-1.
// No backpressure; the counter saturates at terminal count so it can never wrap.
module bridge_watchdog #(
  parameter int RD_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(RD_TIMEOUT) + 1;

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(RD_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sdram_avalon_bridge.sv
// One-at-a-time bridge from the core request handshake to an Avalon-MM master; write done 2 cycles, read 2+valid delay.
// Stalls on waitrequest with command held stable; read watchdog forces completion if readdatavalid never arrives.
module sdram_avalon_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int ADDR_W     = SDRAM_ADDR_W,
  parameter int DATA_W     = SDRAM_DATA_W,
  parameter int RD_TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              sdram_read,
  input  logic              sdram_write,
  input  logic [ADDR_W-1:0] sdram_addr,
  input  logic [DATA_W-1:0] sdram_writedata,
  output logic [DATA_W-1:0] sdram_readdata,
  output logic              sdram_finished,
  output logic              rd_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] new_sdram_controller_0_s1_address,
  output logic [3:0]        new_sdram_controller_0_s1_byteenable_n,
  output logic              new_sdram_controller_0_s1_chipselect,
  output logic [DATA_W-1:0] new_sdram_controller_0_s1_writedata,
  output logic              new_sdram_controller_0_s1_read_n,
  output logic              new_sdram_controller_0_s1_write_n,
  input  logic [DATA_W-1:0] new_sdram_controller_0_s1_readdata,
  input  logic              new_sdram_controller_0_s1_readdatavalid,
  input  logic              new_sdram_controller_0_s1_waitrequest
);

  state_t state, state_nxt;
  logic   wd_tc;
  logic   wd_clr;
  logic   wd_en;
  logic   cmd_nxt;

  assign wd_clr = (state == RD_CMD) && !new_sdram_controller_0_s1_waitrequest;
  assign wd_en  = (state == RD_WAIT);
  assign busy   = (state != IDLE);

  bridge_watchdog #(
    .RD_TIMEOUT(RD_TIMEOUT)
  ) u_watchdog (
    .clk  (i_clk),
    .rst_n(i_rst),
    .clr  (wd_clr),
    .en   (wd_en),
    .tc   (wd_tc)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Write has priority when both requests are presented together.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sdram_write) begin
          state_nxt = WR_CMD;
        end else if (sdram_read) begin
          state_nxt = RD_CMD;
        end
      end
      WR_CMD:  if (!new_sdram_controller_0_s1_waitrequest) state_nxt = DONE;
      RD_CMD:  if (!new_sdram_controller_0_s1_waitrequest) state_nxt = RD_WAIT;
      RD_WAIT: if (new_sdram_controller_0_s1_readdatavalid || wd_tc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_nxt = (state_nxt == WR_CMD) || (state_nxt == RD_CMD);

  // Strobes are decoded from the next state so the bus sees them straight from flops.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      new_sdram_controller_0_s1_chipselect   <= 1'b0;
      new_sdram_controller_0_s1_read_n       <= 1'b1;
      new_sdram_controller_0_s1_write_n      <= 1'b1;
      new_sdram_controller_0_s1_byteenable_n <= BE_NONE_N;
      new_sdram_controller_0_s1_address      <= '0;
      new_sdram_controller_0_s1_writedata    <= '0;
      sdram_readdata                         <= '0;
      sdram_finished                         <= 1'b0;
      rd_timeout                             <= 1'b0;
    end else begin
      new_sdram_controller_0_s1_chipselect   <= cmd_nxt;
      new_sdram_controller_0_s1_read_n       <= (state_nxt != RD_CMD);
      new_sdram_controller_0_s1_write_n      <= (state_nxt != WR_CMD);
      new_sdram_controller_0_s1_byteenable_n <= cmd_nxt ? BE_ALL_N : BE_NONE_N;
      sdram_finished                         <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (sdram_write) begin
            new_sdram_controller_0_s1_address   <= sdram_addr;
            new_sdram_controller_0_s1_writedata <= sdram_writedata;
            rd_timeout                          <= 1'b0;
          end else if (sdram_read) begin
            new_sdram_controller_0_s1_address   <= sdram_addr;
            rd_timeout                          <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (new_sdram_controller_0_s1_readdatavalid) begin
            sdram_readdata <= new_sdram_controller_0_s1_readdata;
          end else if (wd_tc) begin
            sdram_readdata <= '0;
            rd_timeout     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_avalon_bridge.sv
// Bench for sdram_avalon_bridge: directed vector table, hand-written corner sequences,
// then random transactions scored against a transaction-level model.
module tb_sdram_avalon_bridge;

  localparam int TO    = 16;
  localparam int LIMIT = 60;

  typedef struct {
    logic [1:0]  op;     // 0 read, 1 write, 2 read+write together
    logic [22:0] addr;
    logic [31:0] data;
    int          ws;     // waitrequest cycles on the command
    int          d;      // readdatavalid delay after accept (stray for writes)
    logic [31:0] rdata;  // data returned with readdatavalid
    int          fin;    // expected cycle of the finished pulse
    int          cmd;    // expected command cycles on the bus
    logic [31:0] exp_rdata;
    logic        exp_to;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic [22:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] rdata;
  logic        fin;
  logic        to_flag;
  logic        busy;
  logic [22:0] av_addr;
  logic [3:0]  av_be_n;
  logic        av_cs;
  logic [31:0] av_wdata;
  logic        av_rd_n;
  logic        av_wr_n;
  logic [31:0] av_rdata = '0;
  logic        av_rvalid = 1'b0;
  logic        av_wait = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdram_avalon_bridge #(
    .ADDR_W(23), .DATA_W(32), .RD_TIMEOUT(TO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .sdram_read(rd_req),
    .sdram_write(wr_req),
    .sdram_addr(req_addr),
    .sdram_writedata(req_wdata),
    .sdram_readdata(rdata),
    .sdram_finished(fin),
    .rd_timeout(to_flag),
    .busy(busy),
    .new_sdram_controller_0_s1_address(av_addr),
    .new_sdram_controller_0_s1_byteenable_n(av_be_n),
    .new_sdram_controller_0_s1_chipselect(av_cs),
    .new_sdram_controller_0_s1_writedata(av_wdata),
    .new_sdram_controller_0_s1_read_n(av_rd_n),
    .new_sdram_controller_0_s1_write_n(av_wr_n),
    .new_sdram_controller_0_s1_readdata(av_rdata),
    .new_sdram_controller_0_s1_readdatavalid(av_rvalid),
    .new_sdram_controller_0_s1_waitrequest(av_wait)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drives one request through the handshake, watching the Avalon bus each cycle.
  task automatic run_txn(input vec_t v, input string nm);
    int  cs_cnt  = 0;
    int  bad_obs = 0;
    int  fin_at  = -1;
    int  fin_cnt = 0;
    int  vidx;
    logic wr;
    wr   = (v.op != 2'd0);
    vidx = v.ws + 1 + v.d;
    @(negedge clk);
    rd_req    = (v.op != 2'd1);
    wr_req    = (v.op != 2'd0);
    req_addr  = v.addr;
    req_wdata = v.data;
    av_wait   = 1'b1;
    av_rvalid = 1'b0;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      if (av_cs) begin
        cs_cnt++;
        if (av_addr !== v.addr || av_be_n !== 4'h0 || busy !== 1'b1) bad_obs++;
        if (wr && (av_wr_n !== 1'b0 || av_rd_n !== 1'b1 || av_wdata !== v.data)) bad_obs++;
        if (!wr && (av_rd_n !== 1'b0 || av_wr_n !== 1'b1)) bad_obs++;
      end else if (av_be_n !== 4'hF || av_rd_n !== 1'b1 || av_wr_n !== 1'b1) begin
        bad_obs++;
      end
      if (fin) begin
        fin_cnt++;
        if (fin_at < 0) fin_at = k;
        rd_req = 1'b0;
        wr_req = 1'b0;
      end
      if (fin_at > 0 && k > fin_at && k > vidx) break;
      av_wait   = (k <= v.ws);
      av_rvalid = (k == vidx);
      av_rdata  = (k == vidx) ? v.rdata : $urandom;
      req_addr  = 23'($urandom);
      req_wdata = $urandom;
    end
    av_rvalid = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    chk({nm, ".cmd_cycles"}, cs_cnt, v.cmd);
    chk({nm, ".bus"}, bad_obs, 0);
    chk({nm, ".fin_at"}, fin_at, v.fin);
    chk({nm, ".fin_cnt"}, fin_cnt, 1);
    chk({nm, ".rdata"}, rdata, v.exp_rdata);
    chk({nm, ".rd_timeout"}, {31'd0, to_flag}, {31'd0, v.exp_to});
  endtask

  vec_t tbl[8];
  vec_t rv;
  logic [31:0] m_rdata;
  logic        m_to;
  int          fcnt;

  initial begin
    tbl[0] = '{op:2'd1, addr:23'h000010, data:32'hDEADBEEF, ws:0, d:2, rdata:32'h99999999,
               fin:2, cmd:1, exp_rdata:32'h0, exp_to:1'b0};
    tbl[1] = '{op:2'd1, addr:23'h000155, data:32'hA5A5A5A5, ws:5, d:1, rdata:32'h99999999,
               fin:7, cmd:6, exp_rdata:32'h0, exp_to:1'b0};
    tbl[2] = '{op:2'd0, addr:23'h7FFFFF, data:32'h0, ws:0, d:3, rdata:32'h12345678,
               fin:5, cmd:1, exp_rdata:32'h12345678, exp_to:1'b0};
    tbl[3] = '{op:2'd1, addr:23'h000020, data:32'h00000000, ws:0, d:1, rdata:32'h55555555,
               fin:2, cmd:1, exp_rdata:32'h12345678, exp_to:1'b0};
    tbl[4] = '{op:2'd0, addr:23'h000030, data:32'h0, ws:0, d:20, rdata:32'h77777777,
               fin:18, cmd:1, exp_rdata:32'h0, exp_to:1'b1};
    tbl[5] = '{op:2'd2, addr:23'h000040, data:32'hCAFEF00D, ws:1, d:2, rdata:32'h66666666,
               fin:3, cmd:2, exp_rdata:32'h0, exp_to:1'b0};
    tbl[6] = '{op:2'd0, addr:23'h000001, data:32'h0, ws:2, d:1, rdata:32'h0BADF00D,
               fin:5, cmd:3, exp_rdata:32'h0BADF00D, exp_to:1'b0};
    tbl[7] = '{op:2'd0, addr:23'h2AAAAA, data:32'h0, ws:0, d:16, rdata:32'h11223344,
               fin:18, cmd:1, exp_rdata:32'h11223344, exp_to:1'b0};

    repeat (3) @(negedge clk);
    chk("reset.cs_rdn_wrn", {29'd0, av_cs, av_rd_n, av_wr_n}, 32'h3);
    chk("reset.be_n", {28'd0, av_be_n}, 32'hF);
    chk("reset.addr_wdata", {9'd0, av_addr} | av_wdata, 32'h0);
    chk("reset.rdata", rdata, 32'h0);
    chk("reset.fin_to_busy", {29'd0, fin, to_flag, busy}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Stray readdatavalid while idle must not touch the held result.
    fcnt = 0;
    @(negedge clk);
    av_rvalid = 1'b1;
    av_rdata  = 32'hFFFF0000;
    repeat (3) begin
      @(negedge clk);
      if (fin) fcnt++;
    end
    av_rvalid = 1'b0;
    @(negedge clk);
    chk("stray.rdata", rdata, 32'h11223344);
    chk("stray.fin_busy", {fcnt[30:0], busy}, 32'h0);

    // Asynchronous reset while a read command is stalled.
    rd_req   = 1'b1;
    req_addr = 23'h000005;
    av_wait  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid.pre_cs_rdn", {30'd0, av_cs, av_rd_n}, 32'h2);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid.cs_rdn_be", {27'd0, av_cs, av_rd_n, av_be_n}, 32'h1F);
    chk("rst_mid.busy", {31'd0, busy}, 32'h0);
    rd_req  = 1'b0;
    av_wait = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    fcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (fin || av_cs) fcnt++;
    end
    chk("rst_mid.no_fin", fcnt, 0);
    chk("rst_mid.rdata_to", rdata | {31'd0, to_flag}, 32'h0);

    // Random transactions against a transaction-level model.
    m_rdata = 32'h0;
    m_to    = 1'b0;
    for (int n = 0; n < 40; n++) begin
      rv.op    = 2'($urandom_range(0, 2));
      rv.addr  = 23'($urandom);
      rv.data  = $urandom;
      rv.ws    = int'($urandom_range(0, 3));
      rv.rdata = $urandom;
      rv.cmd   = rv.ws + 1;
      if (rv.op == 2'd0) begin
        rv.d   = int'($urandom_range(1, 20));
        rv.fin = rv.ws + 2 + ((rv.d < TO) ? rv.d : TO);
        m_to   = (rv.d > TO);
        m_rdata = m_to ? 32'h0 : rv.rdata;
      end else begin
        rv.d   = int'($urandom_range(1, 4));
        rv.fin = rv.ws + 2;
        m_to   = 1'b0;
      end
      rv.exp_rdata = m_rdata;
      rv.exp_to    = m_to;
      run_txn(rv, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
